dmem_copy_engine: RTL and testbench

//  Bus initiator that copies a block of 16-bit words from one datamem region to another.
//  It drives datamem's address, read_enable, write_enable and write_data ports and samples read_data.

---
 rtl/dmem_copy_pkg.sv | 8 +
 rtl/dmem_copy_csum.sv | 18 +
 rtl/dmem_copy_engine.sv | 80 ++++++++
 tb/tb_dmem_copy_engine.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_copy_pkg.sv
// dmem_copy_pkg: shared widths, FSM state encoding and word/address types for the copy engine
package dmem_copy_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} copy_state_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/dmem_copy_csum.sv
// dmem_copy_csum: clearable wrapping accumulator of copied words (built only with DMEM_COPY_CSUM_EN)
module dmem_copy_csum #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accumulate,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] checksum
);
  // clear on a new transfer, otherwise add each word as it is read
  always_ff @(posedge clk) begin
    if (reset) checksum <= '0;
    else if (clear) checksum <= '0;
    else if (accumulate) checksum <= checksum + data;
  end
endmodule

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: READ/WRITE word-copy DMA over datamem; checksum built only with DMEM_COPY_CSUM_EN
module dmem_copy_engine #(
  parameter int ADDR_W = dmem_copy_pkg::ADDR_W,
  parameter int DATA_W = dmem_copy_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  import dmem_copy_pkg::*;
  copy_state_t state, state_nx;
  logic [ADDR_W-1:0] src_cur, dst_cur, remaining;
  logic [DATA_W-1:0] buffer;
  logic accept;
  assign accept = state == IDLE && start;
  assign mem_write_data = buffer;
  // next state; the last WRITE is the one that drains remaining from 1 to 0
  always_comb begin
    state_nx = state == IDLE  ? (start ? (len == '0 ? DONE : READ) : IDLE) :
               state == READ  ? WRITE :
               state == WRITE ? (remaining == ADDR_W'(1) ? DONE : READ) : IDLE;
  end
  // state, counters, buffer and registered bus outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      src_cur          <= '0;
      dst_cur          <= '0;
      remaining        <= '0;
      buffer           <= '0;
    end else begin
      state            <= state_nx;
      busy             <= state_nx == READ || state_nx == WRITE;
      done             <= state_nx == DONE;
      mem_read_enable  <= state_nx == READ;
      mem_write_enable <= state_nx == WRITE;
      mem_address      <= state_nx == READ  ? (state == IDLE ? src_addr : src_cur + ADDR_W'(1)) :
                          state_nx == WRITE ? dst_cur : mem_address;
      if (accept) begin
        src_cur   <= src_addr;
        dst_cur   <= dst_addr;
        remaining <= len;
      end
      if (state == READ) buffer <= mem_read_data;
      if (state == WRITE) begin
        src_cur   <= src_cur + ADDR_W'(1);
        dst_cur   <= dst_cur + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
    end
  end
`ifdef DMEM_COPY_CSUM_EN
  dmem_copy_csum #(.DATA_W(DATA_W)) u_csum (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .accumulate (state == READ),
    .data       (mem_read_data),
    .checksum   (checksum)
  );
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine: scoreboard bench with a behavioural datamem responder
module tb_dmem_copy_engine;
  import dmem_copy_pkg::*;
  typedef struct {logic [15:0] a; logic [15:0] d;} wr_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, len = '0;
  logic busy, done, mem_read_enable, mem_write_enable;
  logic [15:0] checksum, mem_address, mem_write_data, mem_read_data;
  logic [15:0] mem [0:65535];
  logic tb_we = 1'b0;
  logic [15:0] tb_addr = '0, tb_data = '0;
  int total = 0, bad = 0;
  wr_t q[$];
  logic [15:0] exp_sum;

  dmem_copy_engine dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .checksum(checksum), .mem_address(mem_address),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
      mem[0] <= 16'h441F;
    end else if (mem_write_enable) mem[mem_address] <= mem_write_data;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk); #1 tb_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_mem(input string name, input logic [15:0] a, input logic [15:0] d);
    total++;
    if (mem[a] !== d) begin bad++; $display("FAIL %s mem[%h]=%h expected %h", name, a, mem[a], d); end
  endtask

  // caller is at a negedge; start is raised immediately so back-to-back runs hit the first IDLE cycle
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input int poke_at);
    logic [15:0] sh [logic [15:0]];
    logic [15:0] v, a, b;
    int cyc, busy_n, rd_n;
    bit got;
    wr_t w;
    q.delete(); exp_sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = s + 16'(i); b = d + 16'(i);
      v = sh.exists(a) ? sh[a] : mem[a];
      sh[b] = v; q.push_back('{b, v}); exp_sum += v;
    end
`ifndef DMEM_COPY_CSUM_EN
    exp_sum = '0;
`endif
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; busy_n = 0; rd_n = 0; got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk); cyc++;
      start = (cyc == poke_at);
      if (start) begin src_addr = 16'h0005; dst_addr = 16'h0500; len = 16'd7; end
      if (busy) busy_n++;
      if (mem_read_enable) rd_n++;
      total++;
      if (mem_read_enable && mem_write_enable) begin bad++; $display("FAIL enables_both cycle=%0d", cyc); end
      if (mem_write_enable) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL unexpected_write addr=%h data=%h", mem_address, mem_write_data); end
        else begin
          w = q.pop_front();
          if (mem_address !== w.a || mem_write_data !== w.d) begin
            bad++; $display("FAIL write addr=%h data=%h expected addr=%h data=%h", mem_address, mem_write_data, w.a, w.d);
          end
        end
      end
      if (done) got = 1;
    end
    total++;
    if (!got || cyc != 2 * int'(n) + 1) begin bad++; $display("FAIL latency got=%0d done=%0d expected=%0d", cyc, got, 2 * int'(n) + 1); end
    total++;
    if (busy_n != 2 * int'(n)) begin bad++; $display("FAIL busy_cycles got=%0d expected=%0d", busy_n, 2 * int'(n)); end
    total++;
    if (rd_n != int'(n)) begin bad++; $display("FAIL read_count got=%0d expected=%0d", rd_n, n); end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL missing_writes left=%0d expected=0", q.size()); end
    total++;
    if (checksum !== exp_sum) begin bad++; $display("FAIL checksum got=%h expected=%h", checksum, exp_sum); end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dut.state !== IDLE) begin
      bad++; $display("FAIL after_done busy=%b done=%b state=%0d expected 0 0 IDLE", busy, done, dut.state);
    end
    total++;
    if (checksum !== exp_sum) begin bad++; $display("FAIL checksum_hold got=%h expected=%h", checksum, exp_sum); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_status busy=%b done=%b expected 0 0", busy, done); end
    total++;
    if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      bad++; $display("FAIL reset_enables re=%b we=%b expected 0 0", mem_read_enable, mem_write_enable);
    end
    total++;
    if (mem_address !== 16'h0 || mem_write_data !== 16'h0 || checksum !== 16'h0) begin
      bad++; $display("FAIL reset_regs addr=%h wdata=%h csum=%h expected 0 0 0", mem_address, mem_write_data, checksum);
    end
  endtask

  task automatic test_single;
    run_copy(16'h0000, 16'h0100, 16'd1, 0);
    check_mem("single", 16'h0100, 16'h441F);
  endtask

  task automatic test_block;
    for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), 16'(i + 1));
    run_copy(16'h0010, 16'h0020, 16'd4, 0);
    for (int i = 0; i < 4; i++) check_mem("block", 16'h0020 + 16'(i), 16'(i + 1));
  endtask

  task automatic test_len_zero;
    run_copy(16'h0010, 16'h0090, 16'd0, 0);
    check_mem("len_zero", 16'h0090, 16'h0000);
  endtask

  task automatic test_wrap;
    poke(16'hFFFE, 16'hAAAA);
    poke(16'hFFFF, 16'hBBBB);
    run_copy(16'hFFFE, 16'h0040, 16'd4, 0);
    check_mem("wrap0", 16'h0040, 16'hAAAA);
    check_mem("wrap1", 16'h0041, 16'hBBBB);
    check_mem("wrap2", 16'h0042, 16'h441F);
    check_mem("wrap3", 16'h0043, 16'h0000);
  endtask

  task automatic test_overlap;
    poke(16'h0010, 16'h1234);
    run_copy(16'h0010, 16'h0011, 16'd3, 0);
    for (int i = 1; i < 4; i++) check_mem("overlap", 16'h0010 + 16'(i), 16'h1234);
  endtask

  task automatic test_ignore_start;
    poke(16'h0050, 16'h0111);
    poke(16'h0051, 16'h0222);
    run_copy(16'h0050, 16'h0060, 16'd2, 2);
    run_copy(16'h0050, 16'h0070, 16'd2, 5);
    check_mem("ignore_busy", 16'h0061, 16'h0222);
    check_mem("ignore_done", 16'h0071, 16'h0222);
  endtask

  task automatic test_back_to_back;
    run_copy(16'h0050, 16'h0080, 16'd2, 0);
    run_copy(16'h0080, 16'h0088, 16'd2, 0);
    check_mem("b2b0", 16'h0088, 16'h0111);
    check_mem("b2b1", 16'h0089, 16'h0222);
  endtask

  task automatic test_mid_reset;
    src_addr = 16'h0010; dst_addr = 16'h0030; len = 16'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (mem_write_enable !== 1'b1 || mem_address !== 16'h0031) begin
      bad++; $display("FAIL second_write we=%b addr=%h expected 1 0031", mem_write_enable, mem_address);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (dut.state !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort state=%0d busy=%b done=%b expected IDLE 0 0", dut.state, busy, done);
    end
    total++;
    if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      bad++; $display("FAIL abort_enables re=%b we=%b expected 0 0", mem_read_enable, mem_write_enable);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      bad++; $display("FAIL abort_quiet busy=%b re=%b we=%b expected 0 0 0", busy, mem_read_enable, mem_write_enable);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_block();
    test_len_zero();
    test_wrap();
    test_overlap();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
